// File: rtl/sim_result_monitor_pkg.sv
// Shared types and defaults for the simulation pass/fail/timeout monitor.
package sim_result_monitor_pkg;

    // Monitor FSM encoding.
    typedef enum logic [1:0] {
        SmRun   = 2'd0,
        SmCheck = 2'd1,
        SmDone  = 2'd2
    } sm_state_e;

    // SPM bus direction encoding.
    localparam logic SPM_WRITE = 1'b1;
    localparam logic SPM_READ  = 1'b0;

    // Default address map of the self-checking programs.
    localparam logic [31:0] DEF_HALT_BASE     = 32'd512;
    localparam logic [31:0] DEF_HALT_STRIDE   = 32'd256;
    localparam logic [31:0] DEF_RESULT_BASE   = 32'd2560;
    localparam logic [31:0] DEF_RESULT_STRIDE = 32'd3072;
    localparam logic [31:0] DEF_PASS_VALUE    = 32'd1;

    // Number of set bits in a flag vector (up to 32 harts).
    function automatic int unsigned popcount32(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sim_result_monitor_hart_status_slot.sv
// Per-hart halt/result status tracker with a freeze input.
module sim_result_monitor_hart_status_slot
    import sim_result_monitor_pkg::*;
#(
    parameter int unsigned HART_IDX      = 0,
    parameter int unsigned HART_ID_W     = 2,
    parameter logic [31:0] HALT_BASE     = DEF_HALT_BASE,
    parameter logic [31:0] HALT_STRIDE   = DEF_HALT_STRIDE,
    parameter logic [31:0] RESULT_BASE   = DEF_RESULT_BASE,
    parameter logic [31:0] RESULT_STRIDE = DEF_RESULT_STRIDE,
    parameter logic [31:0] PASS_VALUE    = DEF_PASS_VALUE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic [31:0]          if_pc,
    input  logic [HART_ID_W-1:0] if_hart_id,
    input  logic                 if_valid,
    input  logic [31:0]          spm_addr,
    input  logic                 spm_rw,
    input  logic [31:0]          spm_wr_data,
    input  logic                 spm_valid,
    output logic                 halted,
    output logic                 result_ok,
    output logic                 result_bad,
    output logic                 halted_next,
    output logic                 result_ok_next,
    output logic                 result_bad_next
);

    // 32-bit wrap-around address arithmetic.
    localparam logic [31:0] HALT_ADDR   = HALT_BASE + HART_IDX * HALT_STRIDE;
    localparam logic [31:0] RESULT_ADDR = RESULT_BASE + HART_IDX * RESULT_STRIDE;

    logic halt_hit;
    logic wr_hit;

    // Decode this hart's halt fetch and result write; next flags include this cycle's events.
    always_comb begin
        halt_hit        = if_valid && (32'(if_hart_id) == HART_IDX) && (if_pc == HALT_ADDR);
        wr_hit          = spm_valid && (spm_rw == SPM_WRITE) && (spm_addr == RESULT_ADDR);
        halted_next     = halted | halt_hit;
        result_ok_next  = result_ok | (wr_hit && (spm_wr_data == PASS_VALUE));
        result_bad_next = result_bad | (wr_hit && (spm_wr_data != PASS_VALUE));
    end

    // Sticky flags; held once the verdict is out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted     <= 1'b0;
            result_ok  <= 1'b0;
            result_bad <= 1'b0;
        end else if (!freeze) begin
            halted     <= halted_next;
            result_ok  <= result_ok_next;
            result_bad <= result_bad_next;
        end
    end

endmodule

// File: rtl/sim_result_monitor.sv
// Multi-hart pass/fail/timeout monitor: per-hart status slots plus verdict FSM.
module sim_result_monitor
    import sim_result_monitor_pkg::*;
#(
    parameter int unsigned HART_NUM      = 4,
    parameter int unsigned HART_ID_W     = 2,
    parameter logic [31:0] HALT_BASE     = DEF_HALT_BASE,
    parameter logic [31:0] HALT_STRIDE   = DEF_HALT_STRIDE,
    parameter logic [31:0] RESULT_BASE   = DEF_RESULT_BASE,
    parameter logic [31:0] RESULT_STRIDE = DEF_RESULT_STRIDE,
    parameter logic [31:0] PASS_VALUE    = DEF_PASS_VALUE,
    parameter int unsigned HALT_QUORUM   = 1,
    parameter int unsigned TIMEOUT       = 4000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          if_pc,
    input  logic [HART_ID_W-1:0] if_hart_id,
    input  logic                 if_valid,
    input  logic [31:0]          spm_addr,
    input  logic                 spm_rw,
    input  logic [31:0]          spm_wr_data,
    input  logic                 spm_valid,
    output logic [HART_NUM-1:0]  halted,
    output logic [HART_NUM-1:0]  result_ok,
    output logic [HART_NUM-1:0]  result_bad,
    output logic                 done,
    output logic                 pass,
    output logic                 timed_out,
    output logic [CNT_W-1:0]     cycle_cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    sm_state_e           state;
    logic                freeze;
    logic                quorum;
    logic                verdict;
    logic [HART_NUM-1:0] halted_next;
    logic [HART_NUM-1:0] result_ok_next;
    logic [HART_NUM-1:0] result_bad_next;

    assign freeze = (state == SmDone);

    for (genvar i = 0; i < HART_NUM; i++) begin : g_slot
        sim_result_monitor_hart_status_slot #(
            .HART_IDX      (i),
            .HART_ID_W     (HART_ID_W),
            .HALT_BASE     (HALT_BASE),
            .HALT_STRIDE   (HALT_STRIDE),
            .RESULT_BASE   (RESULT_BASE),
            .RESULT_STRIDE (RESULT_STRIDE),
            .PASS_VALUE    (PASS_VALUE)
        ) u_slot (
            .clk             (clk),
            .reset           (reset),
            .freeze          (freeze),
            .if_pc           (if_pc),
            .if_hart_id      (if_hart_id),
            .if_valid        (if_valid),
            .spm_addr        (spm_addr),
            .spm_rw          (spm_rw),
            .spm_wr_data     (spm_wr_data),
            .spm_valid       (spm_valid),
            .halted          (halted[i]),
            .result_ok       (result_ok[i]),
            .result_bad      (result_bad[i]),
            .halted_next     (halted_next[i]),
            .result_ok_next  (result_ok_next[i]),
            .result_bad_next (result_bad_next[i])
        );
    end

    // Quorum counts halts landing this cycle; verdict sees writes landing during CHECK.
    always_comb begin
        quorum  = popcount32(32'(halted_next)) >= HALT_QUORUM;
        verdict = (result_bad_next == '0) &&
                  ((result_ok_next & halted_next) == halted_next) &&
                  (halted_next != '0);
    end

    // Run/check/done sequencing with saturating cycle counter and registered verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SmRun;
            cycle_cnt <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            unique case (state)
                SmRun: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                    // Quorum takes priority over an expiring budget.
                    if (quorum) begin
                        state <= SmCheck;
                    end else if (cycle_cnt == LAST_CNT) begin
                        state     <= SmDone;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
                SmCheck: begin
                    state <= SmDone;
                    done  <= 1'b1;
                    pass  <= verdict;
                end
                SmDone: begin
                    state <= SmDone;
                end
                default: begin
                    state <= SmDone;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_result_monitor.sv
// Self-checking bench: directed table, multi-cycle corner cases and random stimulus vs model.
module tb_sim_result_monitor;
    import sim_result_monitor_pkg::*;

    localparam int unsigned HN  = 4;
    localparam int unsigned TMO = 4000;
    localparam logic [31:0] HB  = 32'd512;
    localparam logic [31:0] HS  = 32'd256;
    localparam logic [31:0] RB  = 32'd2560;
    localparam logic [31:0] RS  = 32'd3072;
    localparam logic [31:0] PV  = 32'd1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_pc;
    logic [1:0]  if_hart_id;
    logic        if_valid;
    logic [31:0] spm_addr;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic        spm_valid;

    logic [1:0][3:0]  halted_v, ok_v, bad_v;
    logic [1:0]       done_v, pass_v, to_v;
    logic [1:0][31:0] cnt_v;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, one entry per instance (quorum = k+1).
    logic [3:0]  m_h[2], m_ok[2], m_bad[2];
    logic        m_done[2], m_pass[2], m_to[2];
    logic [31:0] m_cnt[2];
    int          m_mode[2];  // 0 running, 1 verdict pending, 2 finished

    always #5 clk = ~clk;

    sim_result_monitor #(.HALT_QUORUM(1)) dut_q1 (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_hart_id(if_hart_id), .if_valid(if_valid),
        .spm_addr(spm_addr), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .spm_valid(spm_valid),
        .halted(halted_v[0]), .result_ok(ok_v[0]), .result_bad(bad_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .timed_out(to_v[0]), .cycle_cnt(cnt_v[0])
    );

    sim_result_monitor #(.HALT_QUORUM(2)) dut_q2 (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_hart_id(if_hart_id), .if_valid(if_valid),
        .spm_addr(spm_addr), .spm_rw(spm_rw), .spm_wr_data(spm_wr_data), .spm_valid(spm_valid),
        .halted(halted_v[1]), .result_ok(ok_v[1]), .result_bad(bad_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .timed_out(to_v[1]), .cycle_cnt(cnt_v[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_dut(input int k);
        return 64'({halted_v[k], ok_v[k], bad_v[k], done_v[k], pass_v[k], to_v[k], cnt_v[k]});
    endfunction

    function automatic logic [63:0] pack_model(input int k);
        return 64'({m_h[k], m_ok[k], m_bad[k], m_done[k], m_pass[k], m_to[k], m_cnt[k]});
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_h[k] = '0; m_ok[k] = '0; m_bad[k] = '0;
            m_done[k] = 1'b0; m_pass[k] = 1'b0; m_to[k] = 1'b0;
            m_cnt[k] = '0; m_mode[k] = 0;
        end
    endtask

    // One clock of the monitor's rules, applied to the inputs present at the edge.
    task automatic model_step(input int k);
        logic [3:0]  h, ok, bad;
        logic [31:0] a;
        if (m_mode[k] == 2) return;
        h = m_h[k]; ok = m_ok[k]; bad = m_bad[k];
        for (int i = 0; i < HN; i++) begin
            a = HB + 32'(i) * HS;
            if (if_valid && int'(if_hart_id) == i && if_pc == a) h[i] = 1'b1;
            a = RB + 32'(i) * RS;
            if (spm_valid && spm_rw == SPM_WRITE && spm_addr == a) begin
                if (spm_wr_data == PV) ok[i] = 1'b1;
                else bad[i] = 1'b1;
            end
        end
        if (m_mode[k] == 0) begin
            if ($countones(h) >= k + 1) begin
                m_mode[k] = 1;
            end else if (m_cnt[k] == TMO - 1) begin
                m_mode[k] = 2; m_done[k] = 1'b1; m_to[k] = 1'b1;
            end
            if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
        end else begin
            m_mode[k] = 2;
            m_done[k] = 1'b1;
            m_pass[k] = (bad == 0) && ((ok & h) == h) && (h != 0);
        end
        m_h[k] = h; m_ok[k] = ok; m_bad[k] = bad;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            model_step(0);
            model_step(1);
        end
        #1;
        check("inst0_model", pack_dut(0), pack_model(0));
        check("inst1_model", pack_dut(1), pack_model(1));
    endtask

    task automatic idle();
        if_valid = 1'b0; if_pc = '0; if_hart_id = '0;
        spm_valid = 1'b0; spm_rw = SPM_READ; spm_addr = '0; spm_wr_data = '0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check("reset_inst0", pack_dut(0), 64'd0);
        check("reset_inst1", pack_dut(1), 64'd0);
    endtask

    task automatic fetch(input logic [1:0] id, input logic [31:0] pc);
        if_valid = 1'b1; if_hart_id = id; if_pc = pc;
    endtask

    task automatic spm(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        spm_valid = 1'b1; spm_rw = rw; spm_addr = addr; spm_wr_data = data;
    endtask

    task automatic run_to_cnt(input logic [31:0] target);
        for (int n = 0; n < 5000 && cnt_v[0] != target; n++) tick();
        check("reach_cnt", 64'(cnt_v[0]), 64'(target));
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [1:0]  hid;
        logic [31:0] hpc;
        logic [3:0]  e_h;
        logic [3:0]  e_ok;
        logic [3:0]  e_bad;
        logic        e_pass;
    } vec_t;

    vec_t vecs[5];

    initial begin
        idle();
        model_reset();

        vecs[0] = '{32'd2560,  32'd1, 2'd0, 32'd512,  4'b0001, 4'b0001, 4'b0000, 1'b1};
        vecs[1] = '{32'd5632,  32'd5, 2'd1, 32'd768,  4'b0010, 4'b0000, 4'b0010, 1'b0};
        vecs[2] = '{32'd11776, 32'd1, 2'd3, 32'd1280, 4'b1000, 4'b1000, 4'b0000, 1'b1};
        vecs[3] = '{32'd8704,  32'd1, 2'd2, 32'd1024, 4'b0100, 4'b0100, 4'b0000, 1'b1};
        vecs[4] = '{32'd2560,  32'd1, 2'd2, 32'd1024, 4'b0100, 4'b0001, 4'b0000, 1'b0};

        // Directed table: result write, then halt fetch, verdict two cycles later.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            spm(SPM_WRITE, vecs[v].waddr, vecs[v].wdata);
            tick();
            idle();
            fetch(vecs[v].hid, vecs[v].hpc);
            tick();
            idle();
            check($sformatf("vec%0d_done_early", v), 64'(done_v[0]), 64'd0);
            tick();
            check($sformatf("vec%0d_done", v), 64'(done_v[0]), 64'd1);
            check($sformatf("vec%0d_pass", v), 64'(pass_v[0]), 64'(vecs[v].e_pass));
            check($sformatf("vec%0d_timed_out", v), 64'(to_v[0]), 64'd0);
            check($sformatf("vec%0d_halted", v), 64'(halted_v[0]), 64'(vecs[v].e_h));
            check($sformatf("vec%0d_ok", v), 64'(ok_v[0]), 64'(vecs[v].e_ok));
            check($sformatf("vec%0d_bad", v), 64'(bad_v[0]), 64'(vecs[v].e_bad));
        end

        // Wrong halt PC for hart 2, then the budget runs out.
        do_reset();
        fetch(2'd2, 32'd512);
        tick();
        idle();
        run_to_cnt(32'd3999);
        check("tmo_halted", 64'(halted_v[0]), 64'd0);
        check("tmo_done_before", 64'(done_v[0]), 64'd0);
        tick();
        check("tmo_done", 64'(done_v[0]), 64'd1);
        check("tmo_timed_out", 64'(to_v[0]), 64'd1);
        check("tmo_pass", 64'(pass_v[0]), 64'd0);
        check("tmo_cnt", 64'(cnt_v[0]), 64'd4000);

        // Quorum of two; a read of a result address is ignored.
        do_reset();
        spm(SPM_READ, 32'd2560, 32'd1);
        tick();
        idle();
        check("q2_read_ignored", 64'(ok_v[1]), 64'd0);
        spm(SPM_WRITE, 32'd2560, 32'd1);
        tick();
        idle();
        fetch(2'd0, 32'd512);
        tick();
        idle();
        tick();
        tick();
        check("q2_one_halt_not_done", 64'(done_v[1]), 64'd0);
        check("q2_one_halt_q1_done", 64'(done_v[0]), 64'd1);
        spm(SPM_WRITE, 32'd11776, 32'd1);
        tick();
        idle();
        fetch(2'd3, 32'd1280);
        tick();
        idle();
        check("q2_done_early", 64'(done_v[1]), 64'd0);
        tick();
        check("q2_done", 64'(done_v[1]), 64'd1);
        check("q2_pass", 64'(pass_v[1]), 64'd1);
        check("q2_halted", 64'(halted_v[1]), 64'b1001);

        // Halt on the last budget cycle: quorum wins; result written during CHECK counts.
        do_reset();
        run_to_cnt(32'd3999);
        fetch(2'd0, 32'd512);
        tick();
        idle();
        spm(SPM_WRITE, 32'd2560, 32'd1);
        tick();
        idle();
        check("race_done", 64'(done_v[0]), 64'd1);
        check("race_timed_out", 64'(to_v[0]), 64'd0);
        check("race_pass", 64'(pass_v[0]), 64'd1);
        check("race_q2_timed_out", 64'(to_v[1]), 64'd1);

        // Asynchronous reset while in CHECK, then a fresh run and post-verdict traffic.
        do_reset();
        fetch(2'd0, 32'd512);
        spm(SPM_WRITE, 32'd2560, 32'd1);
        tick();
        idle();
        #3 reset = 1'b1;
        #1;
        check("areset_inst0", pack_dut(0), 64'd0);
        check("areset_inst1", pack_dut(1), 64'd0);
        model_reset();
        #2 reset = 1'b0;
        spm(SPM_WRITE, 32'd2560, 32'd1);
        tick();
        idle();
        fetch(2'd0, 32'd512);
        tick();
        idle();
        tick();
        check("fresh_pass", 64'(pass_v[0]), 64'd1);
        spm(SPM_WRITE, 32'd2560, 32'd7);
        tick();
        idle();
        fetch(2'd1, 32'd768);
        tick();
        idle();
        tick();
        check("frozen_bad", 64'(bad_v[0]), 64'd0);
        check("frozen_ok", 64'(ok_v[0]), 64'd1);
        check("frozen_halted", 64'(halted_v[0]), 64'd1);
        check("frozen_pass", 64'(pass_v[0]), 64'd1);

        // Random traffic biased towards the interesting addresses.
        for (int r = 0; r < 16; r++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                idle();
                if ($urandom_range(0, 11) == 0) begin
                    if_hart_id = 2'($urandom_range(0, 3));
                    if_pc = ($urandom_range(0, 3) != 0) ?
                            HB + 32'($urandom_range(0, 3)) * HS : 32'($urandom);
                    if_valid = 1'b1;
                end
                if ($urandom_range(0, 5) == 0) begin
                    spm_rw = ($urandom_range(0, 3) != 0) ? SPM_WRITE : SPM_READ;
                    spm_addr = ($urandom_range(0, 3) != 0) ?
                               RB + 32'($urandom_range(0, 3)) * RS : 32'($urandom);
                    spm_wr_data = ($urandom_range(0, 2) != 0) ? PV : 32'($urandom_range(0, 9));
                    spm_valid = 1'b1;
                end
                tick();
            end
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sim_result_monitor.md
Name: sim_result_monitor

Overview:
Synthesizable, parametrised pass/fail/timeout monitor for multi-hart self-checking programs on the FMRT Mini Core. It snoops the IF-stage PC/hart id and the hk MEM-stage SPM write port. It records per-hart halt and result status, then issues one sticky verdict when enough harts have halted, or when a cycle budget expires. Instantiated beside cpu_top in bench or FPGA top level; drives LEDs, a UART reporter or the bench's $finish.

Parameters:
HART_NUM, 4, number of harts monitored
HART_ID_W, 2, width of hart id buses
HALT_BASE, 32'd512, halt PC of hart 0
HALT_STRIDE, 32'd256, halt PC of hart i = HALT_BASE + i*HALT_STRIDE
RESULT_BASE, 32'd2560, result SPM address of hart 0
RESULT_STRIDE, 32'd3072, result address of hart i = RESULT_BASE + i*RESULT_STRIDE
PASS_VALUE, 32'd1, result word meaning success
HALT_QUORUM, 1, halted-hart count that ends the run (1..HART_NUM)
TIMEOUT, 4000, cycle budget after reset release
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
if_pc  in  32  IF-stage fetch PC
if_hart_id  in  HART_ID_W  hart owning if_pc
if_valid  in  1  if_pc/if_hart_id valid this cycle
spm_addr  in  32  MEM-stage SPM address
spm_rw  in  1  `WRITE = write, `READ = read
spm_wr_data  in  32  SPM write data
spm_valid  in  1  SPM access valid this cycle
halted  out  HART_NUM  sticky per-hart halt flags
result_ok  out  HART_NUM  sticky per-hart "wrote PASS_VALUE"
result_bad  out  HART_NUM  sticky per-hart "wrote other value"
done  out  1  verdict valid, sticky
pass  out  1  run passed, valid when done
timed_out  out  1  run ended by budget, valid when done
cycle_cnt  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset is asynchronous. All outputs are 0, cycle_cnt is 0, and the state is RUN. Reset asserted mid-run clears everything immediately.
- States: RUN -> CHECK -> DONE, or RUN -> DONE on timeout. DONE is absorbing until reset.
- RUN:
  - cycle_cnt increments each cycle and saturates at all-ones.
  - Halt detect: when if_valid && if_pc == halt address of hart if_hart_id && if_hart_id < HART_NUM, set halted[if_hart_id]. Repeat fetches have no further effect.
  - Result detect: when spm_valid && spm_rw==`WRITE && spm_addr == result address of some hart i:
    - set result_ok[i] if spm_wr_data==PASS_VALUE, else set result_bad[i].
    - A hart may set both flags on repeated writes.
    - Reads are ignored.
  - Address compares use 32-bit wrap-around arithmetic. Non-matching addresses are ignored.
- Quorum: when the popcount of halted (including bits set this cycle) is >= HALT_QUORUM, go to CHECK the next cycle.
- Timeout: when cycle_cnt == TIMEOUT-1 and quorum is not reached this cycle, go to DONE next cycle with timed_out=1 and pass=0. If quorum and timeout coincide, quorum wins.
- CHECK:
  - Lasts one cycle. Halt and result flags still update, so a result write landing one cycle after the halt fetch is captured.
  - Then DONE with pass = (result_bad==0) && ((result_ok & halted) == halted) && halted!=0.
- DONE:
  - All flags and cycle_cnt freeze, and further bus activity is ignored.
  - done=1, and pass/timed_out are stable.
- Verdict latency: DONE is reached 2 cycles after the quorum-reaching fetch.
- Flag outputs are registered and visible the cycle after the event.

Decomposition:
- Shared header (hart_ctrl.h family, new sim_monitor.h): state encodings SM_RUN/SM_CHECK/SM_DONE (2 bits) and the default address constants.
- `WRITE/`READ and `ENABLE/`DISABLE come from common_defines.v.
- One natural sub-module, hart_status_slot, generated HART_NUM times. It takes the hart index as a parameter, compares its halt and result addresses, and holds halted/result_ok/result_bad for one hart with a freeze input.
- The top holds the FSM, popcount, cycle counter and verdict.

Test Plan:
- Hart 0 writes 1 to addr 2560, then if_pc=512 with hart id 0 -> halted=0001, result_ok=0001, done=1 two cycles after the fetch, pass=1, timed_out=0.
- Hart 1 writes 5 to addr 5632, then fetches 768 with id 1 -> result_bad=0010, done=1, pass=0.
- Hart 2 fetches 512 (wrong halt PC for id 2), with no other activity -> halted stays 0. At cycle_cnt=3999, done=1 and timed_out=1 the next cycle, pass=0.
- HALT_QUORUM=2: hart 0 writes 1 to 2560 and fetches 512; then hart 3 writes 1 to 11776 and fetches 1280 -> done only after the second halt, pass=1. A read of 2560 with rw=`READ changes no flag.
- Hart 0 fetches 512 in the same cycle cycle_cnt=3999 (timeout) -> CHECK wins, timed_out=0. Its result write of 1 arriving during CHECK gives pass=1.
- Reset asserted asynchronously in CHECK -> all outputs 0 in that cycle. Post-DONE writes to 2560 after a fresh run do not alter the frozen flags.
